// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: PC-1 load, per-round C/D rotation, PC-2 subkey stream over valid/ready.
// Optional weak-key flag is built in when DES_WEAK_KEY_DET_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for a key, key_ready high
// S_RUN  | presenting subkey cnt_q, advancing on each subkey handshake
module des_key_sched_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] key,
   input  logic        key_decrypt,
   input  logic        key_valid,
   output logic        key_ready,
   output logic [47:0] subkey,
   output logic [3:0]  subkey_idx,
   output logic        subkey_last,
   output logic        subkey_valid,
   input  logic        subkey_ready
`ifdef DES_WEAK_KEY_DET_EN
   ,
   output logic        weak_key
`endif
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Tables use FIPS numbering: bit 1 is the MSB of the source vector.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
      return r;
   endfunction

   function automatic logic [47:0] des_pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
      return r;
   endfunction

   function automatic logic [1:0] shift_amt(input logic [3:0] idx);
      return (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) ? 2'd1 : 2'd2;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] n);
      return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
   endfunction

   function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] n);
      return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
   endfunction

   logic [0:0]  state_q, state_d;
   logic [55:0] cd_q, cd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        mode_q, mode_d;
   logic        last_q, last_d;
   logic [55:0] pc1_key;
`ifdef DES_WEAK_KEY_DET_EN
   logic        weak_q, weak_d;
`endif

   assign pc1_key = pc1(key);

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      last_d  = last_q;
`ifdef DES_WEAK_KEY_DET_EN
      weak_d  = weak_q;
`endif
      if (state_q == S_IDLE) begin
         if (key_valid) begin
            mode_d  = key_decrypt;
            cnt_d   = 4'd0;
            last_d  = 1'b0;
            // Decrypt starts at K16: the full schedule rotates 28 places, so PC1(key) is already round 16.
            cd_d    = key_decrypt ? pc1_key : rotl_cd(pc1_key, 2'd1);
            state_d = S_RUN;
`ifdef DES_WEAK_KEY_DET_EN
            weak_d  = ((pc1_key[55:28] == '0) || (pc1_key[55:28] == '1)) &&
                      ((pc1_key[27:0]  == '0) || (pc1_key[27:0]  == '1));
`endif
         end
      end else begin
         if (subkey_ready) begin
            if (cnt_q == 4'd15) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
               last_d  = 1'b0;
            end else begin
               cnt_d  = cnt_q + 4'd1;
               last_d = (cnt_q == 4'd14);
               cd_d   = mode_q ? rotr_cd(cd_q, shift_amt(4'd15 - cnt_q))
                               : rotl_cd(cd_q, shift_amt(cnt_q + 4'd1));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cd_q    <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         last_q  <= 1'b0;
`ifdef DES_WEAK_KEY_DET_EN
         weak_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         last_q  <= last_d;
`ifdef DES_WEAK_KEY_DET_EN
         weak_q  <= weak_d;
`endif
      end
   end

   assign key_ready    = (state_q == S_IDLE);
   assign subkey_valid = (state_q == S_RUN);
   assign subkey_idx   = cnt_q;
   assign subkey_last  = last_q;
   assign subkey       = des_pc2(cd_q);
`ifdef DES_WEAK_KEY_DET_EN
   assign weak_key     = weak_q;
`endif

endmodule

// File: doc/des_key_sched_ctrl.md
Name: des_key_sched_ctrl

Overview:
Sequences the DES key schedule: accepts a 64-bit key, applies PC-1 and the per-round C/D rotations, and streams the 16 48-bit round subkeys through the existing des_PC2 permutation. The subkeys go to the round engine over a valid/ready handshake. The sequence runs in encrypt order (K1..K16) or decrypt order (K16..K1). The block sits between the key input interface and the DES round datapath.

Parameters:
None. DES widths are fixed: key 64, C/D 28+28, subkey 48, 16 rounds.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key  input  64  DES key; key[63] is FIPS bit 1; parity bits ignored
key_decrypt  input  1  sampled with key: 0 = K1..K16 order, 1 = K16..K1 order
key_valid  input  1  key/key_decrypt present
key_ready  output  1  block idle, can accept a key
subkey  output  48  current round subkey, des_PC2 output of the CD register
subkey_idx  output  4  sequence position 0..15, not the round number
subkey_last  output  1  high with subkey_idx==15
subkey_valid  output  1  subkey valid
subkey_ready  input  1  round engine consumes subkey

Behaviour:
- Single clock. Reset is asynchronous and active-low. On reset assertion:
  - state=IDLE, CD=0, cnt=0, mode=0.
  - key_ready=1, subkey_valid=0, subkey_idx=0, subkey_last=0.
  - subkey = PC2(0) = 0.
- PC-1 is the standard FIPS 46-3 table, bit 1 = MSB. C = PC1[55:28], D = PC1[27:0].
- Shift table s[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C and D rotate independently.
- States: IDLE, RUN.
- IDLE:
  - key_ready=1, subkey_valid=0.
  - On key_valid&&key_ready, latch mode=key_decrypt and set cnt=0.
  - Load CD = mode ? PC1(key) : rotl(PC1(key),1). Go to RUN.
  - Latency: the first subkey is valid the cycle after the accept handshake.
- RUN:
  - key_ready=0, subkey_valid=1, subkey_idx=cnt, subkey_last=(cnt==15).
  - key_valid is ignored in RUN.
  - While subkey_valid&&!subkey_ready, subkey, subkey_idx and CD are held stable.
  - On handshake with cnt<15:
    - cnt<=cnt+1.
    - Encrypt: CD <= rotl(CD, s[cnt+1]).
    - Decrypt: CD <= rotr(CD, s[15-cnt]).
  - On handshake with cnt==15: go to IDLE, cnt<=0, subkey_valid=0, key_ready=1 in the next cycle.
  - A new key cannot be accepted in the same cycle as the last handshake.
- Decrypt order relies on a total rotation of 28 being identity: K16 = PC2(PC1(key)).
- Throughput: one subkey per cycle while subkey_ready is held high. 17 cycles per key including the accept cycle.
- Reset mid-sequence aborts immediately. A partial sequence is never resumed.
- All outputs are registered except subkey, which is des_PC2 applied combinationally to the CD register.

Optional Feature:
Macro DES_WEAK_KEY_DET_EN.
- When defined:
  - Adds output port weak_key (1 bit), reset value 0.
  - On key accept, weak_key is registered high if C and D are each all-zeros or all-ones after PC-1. This covers the 4 DES weak keys.
  - weak_key holds until the next key accept or reset.
  - Subkey generation is unchanged.
- When undefined: the port and its logic are absent.

Test Plan:
- key=0x133457799BBCDFF1, decrypt=0, subkey_ready=1 -> idx0 subkey=0x1B02EFFC7072 one cycle after accept; idx15 subkey=0xCB3D8B0E17F5 with subkey_last=1; key_ready=1 the following cycle.
- Same key, decrypt=1 -> idx0=0xCB3D8B0E17F5, idx15=0x1B02EFFC7072; all 16 values equal the encrypt run reversed.
- Encrypt run with subkey_ready toggled randomly, including a 5-cycle stall at idx 7 -> subkey/idx held constant during stalls; exactly 16 handshakes; sequence matches the software model.
- key_valid held high during RUN with a different key -> ignored; the first sequence completes unchanged; the second key is accepted only once key_ready=1.
- rst_n asserted asynchronously at idx 9, then released, then a new key applied -> outputs at reset values immediately; fresh sequence starts at idx 0 with correct values.
- DES_WEAK_KEY_DET_EN: key=0x0101010101010101 -> weak_key=1, all subkeys 0; key=0xFEFEFEFEFEFEFEFE -> weak_key=1, all subkeys 0xFFFFFFFFFFFF; key=0x133457799BBCDFF1 -> weak_key=0.
